// File: rtl/butterfly_sched.sv
`default_nettype none
// ============================================================================
// Module   : butterfly_sched
// Desc     : Injection scheduler for a 16-port, 4-stage MSB-first butterfly.
//            Picks a conflict-free subset of offered packets each round,
//            starting from a rotating round-robin pointer. It drives the
//            winners into the network with idle slots zeroed, and registers
//            the network outputs as per-destination results.
// Options  : define BFLY_SCHED_STATS_EN to add the rounds_cnt / defer_cnt
//            saturating statistics outputs.
// Revision : 1.0 - initial release
// ============================================================================
module butterfly_sched #(
   parameter int PKT_W    = 40,
   parameter int DEST_LSB = 0,
   parameter int NPORT    = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NPORT-1:0]       in_valid,
   input  logic [NPORT*PKT_W-1:0] in_pkt,
   output logic [NPORT-1:0]       in_ready,
   input  logic                   stall,
   output logic [NPORT*PKT_W-1:0] net_pkt,
   input  logic [NPORT*PKT_W-1:0] net_res,
   output logic [NPORT-1:0]       out_valid,
   output logic [NPORT*PKT_W-1:0] out_pkt,
   output logic                   busy
`ifdef BFLY_SCHED_STATS_EN
   ,
   output logic [31:0]            rounds_cnt,
   output logic [31:0]            defer_cnt
`endif
);

   // Round phases: IDLE picks and accepts, ISSUE drives the network.
   localparam logic [0:0] c_IDLE  = 1'b0;
   localparam logic [0:0] c_ISSUE = 1'b1;

   // The link arithmetic below is written for exactly four stages.
   if (NPORT != 16) begin : g_nport_check
      $error("butterfly_sched: NPORT must be 16");
   end
   if (DEST_LSB + 4 > PKT_W) begin : g_dest_check
      $error("butterfly_sched: destination field exceeds packet width");
   end

   logic [0:0]             r_state;
   logic [3:0]             r_rr_ptr;
   logic [NPORT-1:0]       r_grant;
   logic [NPORT*PKT_W-1:0] r_hold;
   logic [NPORT-1:0]       r_out_valid;
   logic [NPORT*PKT_W-1:0] r_out_pkt;

   logic [3:0]             w_dest [NPORT];
   logic [NPORT-1:0]       w_conf [NPORT];
   logic [NPORT-1:0]       w_grant;
   logic [3:0]             w_first;
   logic                   w_found;
   logic [3:0]             w_idx;
   logic                   w_start;
   logic [NPORT*PKT_W-1:0] w_hold_d;
   logic [NPORT-1:0]       w_issue_dmask;

   // Two packets collide if they occupy the same link after any stage.
   // After stage k a packet sits on {dest[3:4-k], src[3-k:0]}.
   function automatic logic f_clash(input logic [3:0] s1, input logic [3:0] d1,
                                    input logic [3:0] s2, input logic [3:0] d2);
      logic       clash;
      logic [3:0] dm;
      logic [3:0] sm;
      clash = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         dm = 4'hF << (4 - k);
         sm = ~dm;
         if ((((d1 ^ d2) & dm) == 4'h0) && (((s1 ^ s2) & sm) == 4'h0))
            clash = 1'b1;
      end
      return clash;
   endfunction

   // Per-source destination field and zero-masked capture of the granted packets.
   for (genvar i = 0; i < NPORT; i++) begin : g_slot
      assign w_dest[i] = in_pkt[i*PKT_W + DEST_LSB +: 4];
      assign w_hold_d[i*PKT_W +: PKT_W] = w_grant[i] ? in_pkt[i*PKT_W +: PKT_W]
                                                     : {PKT_W{1'b0}};
   end

   // Pairwise conflict matrix over the currently offered destinations.
   always_comb begin
      for (int i = 0; i < NPORT; i++) begin
         for (int j = 0; j < NPORT; j++) begin
            w_conf[i][j] = (i != j) && f_clash(4'(i), w_dest[i], 4'(j), w_dest[j]);
         end
      end
   end

   // Greedy round-robin scan: take each valid source that clashes with nothing taken so far.
   always_comb begin
      w_grant = '0;
      w_first = 4'h0;
      w_found = 1'b0;
      w_idx   = 4'h0;
      for (int j = 0; j < NPORT; j++) begin
         w_idx = r_rr_ptr + 4'(j);
         if (in_valid[w_idx] && ((w_conf[w_idx] & w_grant) == '0)) begin
            w_grant[w_idx] = 1'b1;
            if (!w_found) begin
               w_found = 1'b1;
               w_first = w_idx;
            end
         end
      end
   end

   // Destinations reached by the round currently in the network.
   always_comb begin
      w_issue_dmask = '0;
      for (int i = 0; i < NPORT; i++) begin
         if (r_grant[i])
            w_issue_dmask[r_hold[i*PKT_W + DEST_LSB +: 4]] = 1'b1;
      end
   end

   assign w_start  = (r_state == c_IDLE) && (|in_valid) && !stall;
   // Handshake is gated by reset so nothing is accepted while rst_n is low.
   assign in_ready = (w_start && rst_n) ? w_grant : '0;
   // Idle slots must be zero because network merge points OR their inputs.
   assign net_pkt  = (r_state == c_ISSUE) ? r_hold : '0;
   assign busy     = (r_state != c_IDLE);
   assign out_valid = r_out_valid;
   assign out_pkt   = r_out_pkt;

   // Round control: accept and latch in IDLE, release to IDLE after one ISSUE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= c_IDLE;
         r_rr_ptr <= 4'h0;
         r_grant  <= '0;
         r_hold   <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_start) begin
                  r_grant  <= w_grant;
                  r_hold   <= w_hold_d;
                  r_rr_ptr <= w_first + 4'd1;
                  r_state  <= c_ISSUE;
               end
            end
            c_ISSUE: begin
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   // Capture network results; out_valid is a single-cycle pulse per round.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= '0;
         r_out_pkt   <= '0;
      end else if (r_state == c_ISSUE) begin
         r_out_valid <= w_issue_dmask;
         r_out_pkt   <= net_res;
      end else begin
         r_out_valid <= '0;
      end
   end

`ifdef BFLY_SCHED_STATS_EN
   logic [31:0] r_rounds_cnt;
   logic [31:0] r_defer_cnt;
   logic [5:0]  w_defer_inc;
   logic [32:0] w_defer_sum;

   assign w_defer_inc = 6'($countones(in_valid & ~w_grant));
   assign w_defer_sum = {1'b0, r_defer_cnt} + {27'h0, w_defer_inc};
   assign rounds_cnt  = r_rounds_cnt;
   assign defer_cnt   = r_defer_cnt;

   // Saturating round and deferral counters, updated at each round start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rounds_cnt <= 32'h0;
         r_defer_cnt  <= 32'h0;
      end else if (w_start) begin
         if (r_rounds_cnt != 32'hFFFF_FFFF)
            r_rounds_cnt <= r_rounds_cnt + 32'd1;
         r_defer_cnt <= w_defer_sum[32] ? 32'hFFFF_FFFF : w_defer_sum[31:0];
      end
   end
`endif

endmodule
`default_nettype wire
